// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcode map, per-opcode decode helpers and the
// decode FSM encoding used by decode_stage.
package decode_stage_pkg;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_SETC = 5'b00001;
  localparam logic [4:0] OP_CLRC = 5'b00010;
  localparam logic [4:0] OP_NOT  = 5'b00011;
  localparam logic [4:0] OP_INC  = 5'b00100;
  localparam logic [4:0] OP_DEC  = 5'b00101;
  localparam logic [4:0] OP_OUT  = 5'b00110;
  localparam logic [4:0] OP_IN   = 5'b00111;
  localparam logic [4:0] OP_IADD = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_ADD  = 5'b01010;
  localparam logic [4:0] OP_SUB  = 5'b01011;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [4:0] OP_OR   = 5'b01101;
  localparam logic [4:0] OP_SHL  = 5'b01110;
  localparam logic [4:0] OP_SHR  = 5'b01111;
  localparam logic [4:0] OP_PUSH = 5'b10000;
  localparam logic [4:0] OP_POP  = 5'b10001;
  localparam logic [4:0] OP_JZ   = 5'b10010;
  localparam logic [4:0] OP_JN   = 5'b10011;
  localparam logic [4:0] OP_JC   = 5'b10100;
  localparam logic [4:0] OP_JMP  = 5'b10101;
  localparam logic [4:0] OP_CALL = 5'b10110;
  localparam logic [4:0] OP_RET  = 5'b10111;
  localparam logic [4:0] OP_LDM  = 5'b11000;
  localparam logic [4:0] OP_LDD  = 5'b11001;
  localparam logic [4:0] OP_STD  = 5'b11010;
  localparam logic [4:0] OP_RTI  = 5'b11011;

  localparam logic [1:0] ST_DEC   = 2'd0;
  localparam logic [1:0] ST_IMM   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  typedef struct packed {
    logic two_word;
    logic uses_rs;
    logic uses_rd;
  } op_info_t;

  // Unlisted opcodes decode as one-word instructions that read no register.
  function automatic op_info_t op_info(input logic [4:0] op);
    op_info_t info;
    info = '{two_word: 1'b0, uses_rs: 1'b0, uses_rd: 1'b0};
    case (op)
      OP_IADD, OP_LDD: begin
        info.two_word = 1'b1;
        info.uses_rs  = 1'b1;
      end
      OP_LDM: info.two_word = 1'b1;
      OP_STD: info = '{two_word: 1'b1, uses_rs: 1'b1, uses_rd: 1'b1};
      OP_MOV: info.uses_rs = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        info.uses_rs = 1'b1;
        info.uses_rd = 1'b1;
      end
      OP_NOT, OP_INC, OP_DEC, OP_OUT, OP_SHL, OP_SHR, OP_PUSH,
      OP_JZ, OP_JN, OP_JC, OP_JMP, OP_CALL: info.uses_rd = 1'b1;
      OP_NOP, OP_SETC, OP_CLRC, OP_IN, OP_POP, OP_RET, OP_RTI: begin
      end
      default: begin
      end
    endcase
    return info;
  endfunction

  function automatic logic is_two_word(input logic [4:0] op);
    op_info_t info;
    info = op_info(op);
    return info.two_word;
  endfunction

  function automatic logic reads_rs(input logic [4:0] op);
    op_info_t info;
    info = op_info(op);
    return info.uses_rs;
  endfunction

  function automatic logic reads_rd(input logic [4:0] op);
    op_info_t info;
    info = op_info(op);
    return info.uses_rd;
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// 8-entry register file with two combinational read ports, one clocked write
// port and write-to-read bypass so a same-cycle writeback is visible to decode.
module decode_stage_reg_file #(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_we,
  input  logic [2:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [2:0]        i_raddr_a,
  input  logic [2:0]        i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_regs [8];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_we && (i_waddr == i_raddr_a)) ? i_wdata : r_regs[i_raddr_a];
  assign o_rdata_b = (i_we && (i_waddr == i_raddr_b)) ? i_wdata : r_regs[i_raddr_b];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: collects two-word instructions, inserts load-use
// bubbles, reads operands and drives the ID/EX pipeline register.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        if_opcode,
  input  logic [2:0]        if_rs,
  input  logic [2:0]        if_rd,
  input  logic [4:0]        if_shmnt,
  input  logic [15:0]       if_word,
  input  logic [PC_W-1:0]   if_pc,
  input  logic              flush,
  input  logic              ex_mem_read,
  input  logic [2:0]        ex_rd,
  input  logic              wb_we,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              fetch_enable,
  output logic              ldm_signal,
  output logic              id_valid,
  output logic [4:0]        id_opcode,
  output logic [2:0]        id_rs_addr,
  output logic [2:0]        id_rd_addr,
  output logic [4:0]        id_shmnt,
  output logic [DATA_W-1:0] id_rs_data,
  output logic [DATA_W-1:0] id_rd_data,
  output logic [PC_W-1:0]   id_imm,
  output logic [PC_W-1:0]   id_pc,
  output logic [1:0]        dbg_state
);

  logic [1:0]        r_state;
  logic              r_ldm;
  logic [4:0]        r_hold_op;
  logic [2:0]        r_hold_rs;
  logic [2:0]        r_hold_rd;
  logic [4:0]        r_hold_sh;
  logic [PC_W-1:0]   r_hold_pc;

  logic              r_id_valid;
  logic [4:0]        r_id_op;
  logic [2:0]        r_id_rs;
  logic [2:0]        r_id_rd;
  logic [4:0]        r_id_sh;
  logic [DATA_W-1:0] r_id_rs_data;
  logic [DATA_W-1:0] r_id_rd_data;
  logic [PC_W-1:0]   r_id_imm;
  logic [PC_W-1:0]   r_id_pc;

  logic [2:0]        w_rs_addr;
  logic [2:0]        w_rd_addr;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rd_data;
  logic [PC_W-1:0]   w_imm_ext;
  logic              w_hazard;

  logic [1:0]        w_nx_state;
  logic              w_nx_ldm;
  logic              w_hold_en;
  logic              w_nx_valid;
  logic [4:0]        w_nx_op;
  logic [2:0]        w_nx_rs;
  logic [2:0]        w_nx_rd;
  logic [4:0]        w_nx_sh;
  logic [DATA_W-1:0] w_nx_rs_data;
  logic [DATA_W-1:0] w_nx_rd_data;
  logic [PC_W-1:0]   w_nx_imm;
  logic [PC_W-1:0]   w_nx_pc;

  // While collecting the immediate the fetch fields are zeroed, so operands
  // are read through the held register addresses instead.
  assign w_rs_addr = (r_state == ST_IMM) ? r_hold_rs : if_rs;
  assign w_rd_addr = (r_state == ST_IMM) ? r_hold_rd : if_rd;
  assign w_imm_ext = PC_W'($signed(if_word));

  decode_stage_reg_file #(.DATA_W(DATA_W)) u_reg_file (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_we      (wb_we),
    .i_waddr   (wb_addr),
    .i_wdata   (wb_data),
    .i_raddr_a (w_rs_addr),
    .i_raddr_b (w_rd_addr),
    .o_rdata_a (w_rs_data),
    .o_rdata_b (w_rd_data)
  );

  // The load has left EX by the STALL cycle, so only DEC checks the hazard.
  assign w_hazard = (r_state == ST_DEC) && ex_mem_read &&
                    ((reads_rs(if_opcode) && (ex_rd == if_rs)) ||
                     (reads_rd(if_opcode) && (ex_rd == if_rd)));

  assign fetch_enable = ~(w_hazard & ~flush & ~reset);

  always_comb begin
    w_nx_state   = r_state;
    w_nx_ldm     = r_ldm;
    w_hold_en    = 1'b0;
    w_nx_valid   = 1'b0;
    w_nx_op      = '0;
    w_nx_rs      = '0;
    w_nx_rd      = '0;
    w_nx_sh      = '0;
    w_nx_rs_data = '0;
    w_nx_rd_data = '0;
    w_nx_imm     = '0;
    w_nx_pc      = '0;
    if (flush) begin
      w_nx_state = ST_DEC;
      w_nx_ldm   = 1'b0;
    end else if (r_state == ST_IMM) begin
      w_nx_valid   = 1'b1;
      w_nx_op      = r_hold_op;
      w_nx_rs      = r_hold_rs;
      w_nx_rd      = r_hold_rd;
      w_nx_sh      = r_hold_sh;
      w_nx_rs_data = w_rs_data;
      w_nx_rd_data = w_rd_data;
      w_nx_imm     = w_imm_ext;
      w_nx_pc      = r_hold_pc;
      w_nx_ldm     = 1'b0;
      w_nx_state   = ST_DEC;
    end else if (w_hazard) begin
      w_nx_state = ST_STALL;
    end else if (if_opcode == OP_NOP) begin
      w_nx_state = ST_DEC;
    end else if (is_two_word(if_opcode)) begin
      // A two-word opcode re-decoded out of STALL also goes to IMM.
      w_hold_en  = 1'b1;
      w_nx_ldm   = 1'b1;
      w_nx_state = ST_IMM;
    end else begin
      w_nx_valid   = 1'b1;
      w_nx_op      = if_opcode;
      w_nx_rs      = if_rs;
      w_nx_rd      = if_rd;
      w_nx_sh      = if_shmnt;
      w_nx_rs_data = w_rs_data;
      w_nx_rd_data = w_rd_data;
      w_nx_pc      = if_pc;
      w_nx_state   = ST_DEC;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_DEC;
      r_ldm        <= 1'b0;
      r_hold_op    <= '0;
      r_hold_rs    <= '0;
      r_hold_rd    <= '0;
      r_hold_sh    <= '0;
      r_hold_pc    <= '0;
      r_id_valid   <= 1'b0;
      r_id_op      <= '0;
      r_id_rs      <= '0;
      r_id_rd      <= '0;
      r_id_sh      <= '0;
      r_id_rs_data <= '0;
      r_id_rd_data <= '0;
      r_id_imm     <= '0;
      r_id_pc      <= '0;
    end else begin
      r_state      <= w_nx_state;
      r_ldm        <= w_nx_ldm;
      if (w_hold_en) begin
        r_hold_op <= if_opcode;
        r_hold_rs <= if_rs;
        r_hold_rd <= if_rd;
        r_hold_sh <= if_shmnt;
        r_hold_pc <= if_pc;
      end
      r_id_valid   <= w_nx_valid;
      r_id_op      <= w_nx_op;
      r_id_rs      <= w_nx_rs;
      r_id_rd      <= w_nx_rd;
      r_id_sh      <= w_nx_sh;
      r_id_rs_data <= w_nx_rs_data;
      r_id_rd_data <= w_nx_rd_data;
      r_id_imm     <= w_nx_imm;
      r_id_pc      <= w_nx_pc;
    end
  end

  assign ldm_signal = r_ldm;
  assign id_valid   = r_id_valid;
  assign id_opcode  = r_id_op;
  assign id_rs_addr = r_id_rs;
  assign id_rd_addr = r_id_rd;
  assign id_shmnt   = r_id_sh;
  assign id_rs_data = r_id_rs_data;
  assign id_rd_data = r_id_rd_data;
  assign id_imm     = r_id_imm;
  assign id_pc      = r_id_pc;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios followed by a randomized program
// fed through a small fetch model and checked against an issued-stream model.
module tb_decode_stage;

  localparam int DATA_W = 16;
  localparam int PC_W   = 32;
  localparam int EXP_W  = 112;
  localparam int N_OPS  = 22;

  localparam logic [4:0] T_NOP  = 5'b00000;
  localparam logic [4:0] T_SETC = 5'b00001;
  localparam logic [4:0] T_NOT  = 5'b00011;
  localparam logic [4:0] T_INC  = 5'b00100;
  localparam logic [4:0] T_DEC  = 5'b00101;
  localparam logic [4:0] T_OUT  = 5'b00110;
  localparam logic [4:0] T_IN   = 5'b00111;
  localparam logic [4:0] T_IADD = 5'b01000;
  localparam logic [4:0] T_MOV  = 5'b01001;
  localparam logic [4:0] T_ADD  = 5'b01010;
  localparam logic [4:0] T_SUB  = 5'b01011;
  localparam logic [4:0] T_AND  = 5'b01100;
  localparam logic [4:0] T_OR   = 5'b01101;
  localparam logic [4:0] T_SHL  = 5'b01110;
  localparam logic [4:0] T_SHR  = 5'b01111;
  localparam logic [4:0] T_PUSH = 5'b10000;
  localparam logic [4:0] T_POP  = 5'b10001;
  localparam logic [4:0] T_JZ   = 5'b10010;
  localparam logic [4:0] T_JN   = 5'b10011;
  localparam logic [4:0] T_JC   = 5'b10100;
  localparam logic [4:0] T_JMP  = 5'b10101;
  localparam logic [4:0] T_CALL = 5'b10110;
  localparam logic [4:0] T_RET  = 5'b10111;
  localparam logic [4:0] T_LDM  = 5'b11000;
  localparam logic [4:0] T_LDD  = 5'b11001;
  localparam logic [4:0] T_STD  = 5'b11010;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0]        if_opcode;
  logic [2:0]        if_rs;
  logic [2:0]        if_rd;
  logic [4:0]        if_shmnt;
  logic [15:0]       if_word;
  logic [PC_W-1:0]   if_pc;
  logic              flush;
  logic              ex_mem_read;
  logic [2:0]        ex_rd;
  logic              wb_we;
  logic [2:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              fetch_enable;
  logic              ldm_signal;
  logic              id_valid;
  logic [4:0]        id_opcode;
  logic [2:0]        id_rs_addr;
  logic [2:0]        id_rd_addr;
  logic [4:0]        id_shmnt;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rd_data;
  logic [PC_W-1:0]   id_imm;
  logic [PC_W-1:0]   id_pc;
  logic [1:0]        dbg_state;

  decode_stage #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_opcode    (if_opcode),
    .if_rs        (if_rs),
    .if_rd        (if_rd),
    .if_shmnt     (if_shmnt),
    .if_word      (if_word),
    .if_pc        (if_pc),
    .flush        (flush),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .fetch_enable (fetch_enable),
    .ldm_signal   (ldm_signal),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_rs_addr   (id_rs_addr),
    .id_rd_addr   (id_rd_addr),
    .id_shmnt     (id_shmnt),
    .id_rs_data   (id_rs_data),
    .id_rd_data   (id_rd_data),
    .id_imm       (id_imm),
    .id_pc        (id_pc),
    .dbg_state    (dbg_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [EXP_W-1:0]  exp_q[$];
  logic [DATA_W-1:0] ref_regs [8];
  logic [15:0]       prog [256];
  logic [4:0]        op_list [N_OPS];

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"},   128'(id_valid),     128'(0));
    check({tag, "_opcode"},  128'(id_opcode),    128'(0));
    check({tag, "_rs_addr"}, 128'(id_rs_addr),   128'(0));
    check({tag, "_rd_addr"}, 128'(id_rd_addr),   128'(0));
    check({tag, "_shmnt"},   128'(id_shmnt),     128'(0));
    check({tag, "_rs_data"}, 128'(id_rs_data),   128'(0));
    check({tag, "_rd_data"}, 128'(id_rd_data),   128'(0));
    check({tag, "_imm"},     128'(id_imm),       128'(0));
    check({tag, "_pc"},      128'(id_pc),        128'(0));
    check({tag, "_fetch_en"},128'(fetch_enable), 128'(1));
    check({tag, "_ldm"},     128'(ldm_signal),   128'(0));
  endtask

  // ISA reference: which opcodes are two words and which fields they read
  function automatic logic tb_two_word(input logic [4:0] op);
    return op inside {T_LDM, T_IADD, T_LDD, T_STD};
  endfunction

  function automatic logic tb_reads_rs(input logic [4:0] op);
    return op inside {T_MOV, T_ADD, T_SUB, T_AND, T_OR, T_IADD, T_LDD, T_STD};
  endfunction

  function automatic logic tb_reads_rd(input logic [4:0] op);
    return op inside {T_NOT, T_INC, T_DEC, T_OUT, T_ADD, T_SUB, T_AND, T_OR, T_SHL,
                      T_SHR, T_PUSH, T_JZ, T_JN, T_JC, T_JMP, T_CALL, T_STD};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rd,
                            input logic [4:0] sh);
    if_opcode = op;
    if_rs     = rs;
    if_rd     = rd;
    if_shmnt  = sh;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0]     word;
    logic [4:0]      op;
    logic [2:0]      rs;
    logic [2:0]      rd;
    logic [4:0]      sh;
    logic [PC_W-1:0] imm;
    logic [PC_W-1:0] base;
    logic [EXP_W-1:0] got;
    logic [EXP_W-1:0] want;
    logic            exp_fe;
    logic            prev_fe_low;
    int              n_words;
    int              idx;
    int              cycles;

    op_list = '{T_NOP, T_SETC, T_NOT, T_INC, T_OUT, T_IN, T_MOV, T_ADD, T_SUB, T_AND, T_OR,
                T_SHL, T_PUSH, T_POP, T_JZ, T_JMP, T_CALL, T_RET, T_IADD, T_LDM, T_LDD, T_STD};
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;
    for (int i = 0; i < 256; i++) prog[i] = '0;

    reset = 1'b1;
    set_fields(T_NOP, 0, 0, 0);
    if_word = '0; if_pc = '0; flush = 1'b0;
    ex_mem_read = 1'b0; ex_rd = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset_state_dec", 128'(dbg_state), 128'(decode_stage_pkg::ST_DEC));
    reset = 1'b0;

    // write R3 then decode ADD reading it
    wb_we = 1'b1; wb_addr = 3'd3; wb_data = 16'h00AB;
    tick();
    wb_we = 1'b0;
    set_fields(T_ADD, 3'd3, 3'd1, 5'd0); if_pc = 32'h10;
    tick();
    check("add_valid",   128'(id_valid),   128'(1));
    check("add_opcode",  128'(id_opcode),  128'(T_ADD));
    check("add_rs_data", 128'(id_rs_data), 128'(16'h00AB));
    check("add_rd_data", 128'(id_rd_data), 128'(16'h0000));
    check("add_imm",     128'(id_imm),     128'(0));
    check("add_pc",      128'(id_pc),      128'(32'h10));

    // same-cycle writeback bypass
    set_fields(T_MOV, 3'd5, 3'd0, 5'd0); if_pc = 32'h11;
    wb_we = 1'b1; wb_addr = 3'd5; wb_data = 16'h1234;
    tick();
    wb_we = 1'b0;
    check("bypass_rs_data", 128'(id_rs_data), 128'(16'h1234));
    check("bypass_valid",   128'(id_valid),   128'(1));
    set_fields(T_ADD, 3'd5, 3'd3, 5'd7); if_pc = 32'h12;
    tick();
    check("stored_rs_data", 128'(id_rs_data), 128'(16'h1234));
    check("stored_rd_data", 128'(id_rd_data), 128'(16'h00AB));
    check("stored_shmnt",   128'(id_shmnt),   128'(7));

    // LDM R2, FF80
    set_fields(T_LDM, 3'd0, 3'd2, 5'd0); if_pc = 32'h40; if_word = {T_LDM, 3'd0, 3'd2, 5'd0};
    #1;
    check("ldm_fetch_en", 128'(fetch_enable), 128'(1));
    tick();
    check("ldm_bubble", 128'(id_valid),   128'(0));
    check("ldm_signal", 128'(ldm_signal), 128'(1));
    set_fields(T_NOP, 0, 0, 0); if_word = 16'hFF80; if_pc = 32'h41;
    tick();
    check("ldm_valid",   128'(id_valid),   128'(1));
    check("ldm_opcode",  128'(id_opcode),  128'(T_LDM));
    check("ldm_imm",     128'(id_imm),     128'(32'hFFFF_FF80));
    check("ldm_rd_addr", 128'(id_rd_addr), 128'(2));
    check("ldm_pc",      128'(id_pc),      128'(32'h40));
    check("ldm_cleared", 128'(ldm_signal), 128'(0));

    // load-use hazard on Rs
    set_fields(T_ADD, 3'd4, 3'd1, 5'd0); if_pc = 32'h42;
    ex_mem_read = 1'b1; ex_rd = 3'd4;
    #1;
    check("hz_rs_fetch_stall", 128'(fetch_enable), 128'(0));
    tick();
    check("hz_rs_bubble",   128'(id_valid),     128'(0));
    check("hz_rs_fetch_on", 128'(fetch_enable), 128'(1));
    ex_mem_read = 1'b0;
    tick();
    check("hz_rs_issue",   128'(id_valid),   128'(1));
    check("hz_rs_rs_addr", 128'(id_rs_addr), 128'(4));
    check("hz_rs_pc",      128'(id_pc),      128'(32'h42));

    // matching register but unread field: no stall
    set_fields(T_IN, 3'd4, 3'd4, 5'd0); if_pc = 32'h43;
    ex_mem_read = 1'b1; ex_rd = 3'd4;
    #1;
    check("hz_unread_fetch_en", 128'(fetch_enable), 128'(1));
    tick();
    check("hz_unread_issue", 128'(id_opcode), 128'(T_IN));

    // hazard on Rd of an Rd-reading opcode; load still present during STALL
    set_fields(T_NOT, 3'd0, 3'd4, 5'd0); if_pc = 32'h44;
    #1;
    check("hz_rd_fetch_stall", 128'(fetch_enable), 128'(0));
    tick();
    check("hz_rd_bubble", 128'(id_valid), 128'(0));
    tick();
    check("hz_rd_issue", 128'(id_opcode), 128'(T_NOT));
    check("hz_rd_valid", 128'(id_valid),  128'(1));

    // different destination: no stall
    set_fields(T_ADD, 3'd3, 3'd2, 5'd0); if_pc = 32'h45;
    #1;
    check("hz_other_fetch_en", 128'(fetch_enable), 128'(1));
    ex_mem_read = 1'b0;
    tick();

    // flush while waiting for the immediate
    set_fields(T_LDM, 3'd0, 3'd6, 5'd0); if_pc = 32'h50;
    tick();
    check("flush_imm_ldm", 128'(ldm_signal), 128'(1));
    set_fields(T_NOP, 0, 0, 0); if_word = 16'h7777; if_pc = 32'h51; flush = 1'b1;
    #1;
    check("flush_fetch_en", 128'(fetch_enable), 128'(1));
    tick();
    check("flush_bubble",    128'(id_valid),   128'(0));
    check("flush_ldm_clear", 128'(ldm_signal), 128'(0));
    flush = 1'b0;
    tick();
    check("flush_no_issue", 128'(id_valid), 128'(0));

    // flush in DEC beats a valid opcode
    set_fields(T_ADD, 3'd1, 3'd1, 5'd0); if_pc = 32'h52; flush = 1'b1;
    tick();
    check("flush_dec_bubble", 128'(id_valid), 128'(0));
    flush = 1'b0;
    set_fields(T_NOP, 0, 0, 0);
    tick();
    check("nop_bubble", 128'(id_valid), 128'(0));

    // asynchronous reset in the middle of STALL
    set_fields(T_ADD, 3'd4, 3'd4, 5'd0); if_pc = 32'h58;
    ex_mem_read = 1'b1; ex_rd = 3'd4;
    #1;
    check("rst_stall_enter", 128'(fetch_enable), 128'(0));
    tick();
    #2 reset = 1'b1;
    #1;
    check_idle("rst_stall");
    #2 reset = 1'b0;
    ex_mem_read = 1'b0;
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;

    // register file cleared by reset
    set_fields(T_ADD, 3'd5, 3'd3, 5'd0); if_pc = 32'h60;
    tick();
    check("rst_regs_valid",   128'(id_valid),   128'(1));
    check("rst_regs_rs_data", 128'(id_rs_data), 128'(0));
    check("rst_regs_rd_data", 128'(id_rd_data), 128'(0));
    check("rst_regs_pc",      128'(id_pc),      128'(32'h60));
    #2 reset = 1'b1;
    #1;
    check_idle("rst_after_issue");
    #2 reset = 1'b0;

    // reset while waiting for the immediate discards the held LDM
    set_fields(T_LDM, 3'd0, 3'd1, 5'd0); if_pc = 32'h70;
    tick();
    check("rst_imm_ldm", 128'(ldm_signal), 128'(1));
    #2 reset = 1'b1;
    #1;
    check("rst_imm_ldm_clear", 128'(ldm_signal), 128'(0));
    #2 reset = 1'b0;
    set_fields(T_NOP, 0, 0, 0); if_word = 16'h1234; if_pc = 32'h71;
    tick();
    check("rst_imm_no_issue", 128'(id_valid), 128'(0));

    // preload the register file with random values
    for (int r = 0; r < 8; r++) begin
      wb_we = 1'b1; wb_addr = 3'(r); wb_data = 16'($urandom);
      ref_regs[r] = wb_data;
      tick();
    end
    wb_we = 1'b0;

    // random program and its expected issued stream
    base = 32'h200;
    n_words = 0;
    for (int k = 0; k < 40; k++) begin
      op = op_list[$urandom_range(0, N_OPS - 1)];
      rs = 3'($urandom_range(0, 7));
      rd = 3'($urandom_range(0, 7));
      sh = 5'($urandom_range(0, 31));
      prog[n_words] = {op, rs, rd, sh};
      want = '0;
      imm  = '0;
      if (tb_two_word(op)) begin
        word = 16'($urandom);
        prog[n_words + 1] = word;
        imm = {{16{word[15]}}, word};
      end
      if (op != T_NOP)
        exp_q.push_back({op, rs, rd, sh, ref_regs[rs], ref_regs[rd], imm, base + PC_W'(n_words)});
      n_words += tb_two_word(op) ? 2 : 1;
    end

    idx = 0;
    cycles = 0;
    prev_fe_low = 1'b0;
    while ((idx < n_words || exp_q.size() != 0) && cycles < 2000) begin
      word = prog[idx];
      if (ldm_signal) set_fields(T_NOP, 0, 0, 0);
      else set_fields(word[15:11], word[10:8], word[7:5], word[4:0]);
      if_word = word;
      if_pc   = base + PC_W'(idx);
      ex_mem_read = ($urandom_range(0, 9) < 3);
      ex_rd = 3'($urandom_range(0, 7));
      #1;
      if (ldm_signal || prev_fe_low) exp_fe = 1'b1;
      else exp_fe = !(ex_mem_read && ((tb_reads_rs(if_opcode) && ex_rd == if_rs) ||
                                      (tb_reads_rd(if_opcode) && ex_rd == if_rd)));
      check("rand_fetch_enable", 128'(fetch_enable), 128'(exp_fe));
      prev_fe_low = !exp_fe;
      if (fetch_enable) idx++;
      tick();
      if (id_valid) begin
        check("rand_issue_expected", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          got  = {id_opcode, id_rs_addr, id_rd_addr, id_shmnt, id_rs_data, id_rd_data, id_imm, id_pc};
          check("rand_issue", 128'(got), 128'(want));
        end
      end
      cycles++;
    end
    ex_mem_read = 1'b0;
    check("rand_drained", 128'(exp_q.size()), 128'(0));
    check("rand_in_budget", 128'(cycles < 2000), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 16: register and immediate data width.
REQ-002 Parameter PC_W, default 32: program-counter width.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 if_opcode/if_rs/if_rd/if_shmnt  in  5/3/3/5  IF/ID instruction fields from fetch; forced to zero by fetch while ldm_signal=1.
REQ-006 if_word  in  16  raw fetched word, never zeroed; carries the immediate.
REQ-007 if_pc  in  PC_W  address of the word on if_word.
REQ-008 flush  in  1  taken branch, jump, return or interrupt redirect from EX.
REQ-009 ex_mem_read, ex_rd  in  1, 3  EX stage holds a load and its destination register.
REQ-010 wb_we, wb_addr, wb_data  in  1, 3, DATA_W  register-file write port.
REQ-011 fetch_enable  out  1  0 stalls fetch; drives the fetch enable input.
REQ-012 ldm_signal  out  1  1 means the current fetch word is an immediate; drives the fetch LDM_signal input.
REQ-013 id_valid, id_opcode, id_rs_addr, id_rd_addr, id_shmnt  out  1/5/3/3/5  ID/EX register.
REQ-014 id_rs_data, id_rd_data  out  DATA_W each  register operands.
REQ-015 id_imm, id_pc  out  PC_W each  sign-extended immediate and instruction PC.

Function
REQ-016 The state machine SHALL have three states: DEC (default), IMM (waiting for the immediate word) and STALL (one load-use bubble).
REQ-017 In DEC, a two-word opcode SHALL latch its fields and PC into holding registers, emit a bubble (id_valid=0), set ldm_signal=1 from the next cycle, and go to IMM.
REQ-018 In IMM, the block SHALL capture if_word, output it as id_imm sign-extended to PC_W, emit the held instruction with id_valid=1, clear ldm_signal, and return to DEC.
REQ-019 In DEC, a one-word opcode SHALL be registered into ID/EX with id_valid=1 and id_imm=0 on the next edge, giving one-cycle latency.
REQ-020 Load-use hazard: in DEC, ex_mem_read=1 with ex_rd equal to if_rs or if_rd, for an opcode that reads that field, SHALL drive fetch_enable=0 combinationally, emit a bubble, and go to STALL.
REQ-021 In STALL, fetch_enable SHALL be 1, and the block SHALL re-decode the unchanged IF/ID fields and return to DEC.
REQ-022 flush SHALL have the highest priority in every state: emit a bubble, discard any held instruction, clear ldm_signal, and go to DEC.
REQ-023 An opcode of zero (NOP or bubble from fetch) SHALL produce id_valid=0.
REQ-024 Register file: 8 x DATA_W, two combinational read ports and one write port updated on the clock edge; R0 is an ordinary register.
REQ-025 Read bypass: when wb_we=1 and wb_addr matches the register being read, the read SHALL return wb_data in the same cycle.
REQ-026 id_pc SHALL be the address of the first word of the instruction, including two-word instructions.

Reset
REQ-027 Reset SHALL put the state machine in DEC, clear all ID/EX outputs to 0, drive fetch_enable=1 and ldm_signal=0, and clear all registers to 0.
REQ-028 Reset asserted during IMM or STALL SHALL discard the held instruction; no partial instruction is issued after reset.

Structure
REQ-029 A shared package SHALL hold:
- the opcode constants, with two-word opcodes LDM=5'b11000, IADD=5'b01000, LDD=5'b11001, STD=5'b11010;
- the is_two_word and reads_rs/reads_rd helper functions;
- the state encoding DEC/IMM/STALL.
REQ-030 The register file SHALL be one sub-module, reg_file, containing the bypass logic.

Verification
REQ-031 Scenario: after reset, write 16'h00AB to R3, then decode ADD with Rs=3 -> id_rs_data=16'h00AB, id_valid=1 one cycle later.
REQ-032 Scenario: LDM R2 followed by word 16'hFF80 -> one bubble, ldm_signal=1 for one cycle, then id_imm=32'hFFFFFF80, id_rd_addr=2, id_pc equal to the LDM address.
REQ-033 Scenario: ex_mem_read=1, ex_rd=4, with a decode reading Rs=4 -> fetch_enable=0 for one cycle, one bubble, then the instruction issues with id_valid=1.
REQ-034 Scenario: flush asserted while in IMM -> id_valid=0, ldm_signal=0 next cycle, held LDM never issued.
REQ-035 Scenario: wb_we=1, wb_addr=5, wb_data=16'h1234 in the same cycle as a decode reading R5 -> id_rs_data=16'h1234.
REQ-036 Scenario: reset asserted asynchronously mid-STALL -> all outputs 0, fetch_enable=1 immediately, without waiting for a clock edge.
